// File: rtl/ddram_arb.sv
// ddram_arb: shares the MiSTer DDR3 Avalon-MM port between video (port 0) and CPU (port 1).
// Round-robin by default; define DDRAM_ARB_FIXPRIO_EN to give port 0 strict priority.
module ddram_arb #(
    parameter int AW = 29,
    parameter int BW = 8
) (
    input  logic          clk,
    input  logic          _reset,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [BW-1:0] r0_burstcnt,
    input  logic [63:0]   r0_din,
    input  logic [7:0]    r0_be,
    output logic          r0_ack,
    output logic [63:0]   r0_dout,
    output logic          r0_rdvalid,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [BW-1:0] r1_burstcnt,
    input  logic [63:0]   r1_din,
    input  logic [7:0]    r1_be,
    output logic          r1_ack,
    output logic [63:0]   r1_dout,
    output logic          r1_rdvalid,

    input  logic          DDRAM_BUSY,
    output logic [BW-1:0] DDRAM_BURSTCNT,
    output logic [AW-1:0] DDRAM_ADDR,
    output logic          DDRAM_RD,
    output logic          DDRAM_WE,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT} state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [63:0]   din_q, din_d;
    logic [7:0]    be_q, be_d;
`ifndef DDRAM_ARB_FIXPRIO_EN
    logic          last_q, last_d;
`endif

    logic          win;
    logic          win_we;
    logic [BW-1:0] win_bc;
    logic          accept;
    logic          beat;
    logic [BW-1:0] cnt_inc;

    always_comb begin
`ifdef DDRAM_ARB_FIXPRIO_EN
        win = ~r0_req;
`else
        win = (r0_req & r1_req) ? ~last_q : r1_req;
`endif
    end

    assign win_we  = win ? r1_we : r0_we;
    assign win_bc  = win ? r1_burstcnt : r0_burstcnt;
    assign accept  = (rd_q | wr_q) & ~DDRAM_BUSY;
    // Beats may arrive while the read strobe is still up (controller fast path).
    assign beat    = DDRAM_DOUT_READY & (((state_q == S_ISSUE) & rd_q) | (state_q == S_RDWAIT));
    assign cnt_inc = cnt_q + {{(BW-1){1'b0}}, beat};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        addr_d  = addr_q;
        din_d   = din_q;
        be_d    = be_q;
`ifndef DDRAM_ARB_FIXPRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (r0_req | r1_req) begin
                    owner_d = win;
`ifndef DDRAM_ARB_FIXPRIO_EN
                    last_d  = win;
`endif
                    rd_d    = ~win_we;
                    wr_d    = win_we;
                    burst_d = (win_we || win_bc == '0) ? {{(BW-1){1'b0}}, 1'b1} : win_bc;
                    addr_d  = win ? r1_addr : r0_addr;
                    din_d   = win ? r1_din : r0_din;
                    be_d    = win ? r1_be : r0_be;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = cnt_inc;
                if (accept) begin
                    rd_d = 1'b0;
                    wr_d = 1'b0;
                    if (wr_q || cnt_inc >= burst_q) state_d = S_IDLE;
                    else                             state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= burst_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            burst_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            be_q    <= '0;
`ifndef DDRAM_ARB_FIXPRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            be_q    <= be_d;
`ifndef DDRAM_ARB_FIXPRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = wr_q;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_BURSTCNT = burst_q;
    assign DDRAM_DIN      = din_q;
    assign DDRAM_BE       = be_q;

    assign r0_ack     = accept & ~owner_q;
    assign r1_ack     = accept & owner_q;
    assign r0_rdvalid = beat & ~owner_q;
    assign r1_rdvalid = beat & owner_q;
    assign r0_dout    = DDRAM_DOUT;
    assign r1_dout    = DDRAM_DOUT;
endmodule

// File: tb/tb_ddram_arb.sv
// Bench for ddram_arb: transaction-level model of the shared DDR3 port checked every cycle,
// plus directed scenarios with hand-computed expectations and a randomized traffic phase.
`timescale 1ns/1ps
module tb_ddram_arb;
    localparam int AW = 29;
    localparam int BW = 8;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [BW-1:0] bc;
        logic [63:0]   din;
        logic [7:0]    be;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req    [2];
    logic          we_i   [2];
    logic [AW-1:0] addr_i [2];
    logic [BW-1:0] bc_i   [2];
    logic [63:0]   din_i  [2];
    logic [7:0]    be_i   [2];
    logic          ack    [2];
    logic [63:0]   dout   [2];
    logic          rdv    [2];
    logic          busy, ready;
    logic [63:0]   ddout;
    logic [BW-1:0] d_bc;
    logic [AW-1:0] d_addr;
    logic          d_rd, d_we;
    logic [63:0]   d_din;
    logic [7:0]    d_be;

    ddram_arb #(.AW(AW), .BW(BW)) dut (
        .clk(clk), ._reset(rst_n),
        .r0_req(req[0]), .r0_we(we_i[0]), .r0_addr(addr_i[0]), .r0_burstcnt(bc_i[0]),
        .r0_din(din_i[0]), .r0_be(be_i[0]), .r0_ack(ack[0]), .r0_dout(dout[0]), .r0_rdvalid(rdv[0]),
        .r1_req(req[1]), .r1_we(we_i[1]), .r1_addr(addr_i[1]), .r1_burstcnt(bc_i[1]),
        .r1_din(din_i[1]), .r1_be(be_i[1]), .r1_ack(ack[1]), .r1_dout(dout[1]), .r1_rdvalid(rdv[1]),
        .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(d_bc), .DDRAM_ADDR(d_addr), .DDRAM_RD(d_rd),
        .DDRAM_WE(d_we), .DDRAM_DIN(d_din), .DDRAM_BE(d_be), .DDRAM_DOUT(ddout),
        .DDRAM_DOUT_READY(ready)
    );

    always #5 clk = ~clk;

    // Stimulus controls, requester queues, observations
    bit   rst_v, busy_v, ready_v;
    cmd_t pend0[$];
    cmd_t pend1[$];
    int   ack_log[$];
    int   rdv_cnt [2];
    int   n_err, n_chk;
    logic s_rd, s_we;
    logic s_ack [2];
    logic s_rdv [2];
    logic [AW-1:0] s_addr;
    logic [BW-1:0] s_bc;
    logic [63:0]   s_din;
    logic [7:0]    s_be;

    // Model: at most one command in flight; strobe up until accepted, then beats until len
    bit            m_active, m_acc, m_we, m_port, m_last;
    logic [AW-1:0] m_addr;
    logic [63:0]   m_din;
    logic [7:0]    m_be;
    int            m_len, m_got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input bit w, input logic [AW-1:0] a, input logic [BW-1:0] b,
                                input logic [63:0] d, input logic [7:0] e);
        cmd_t c;
        c.we = w; c.addr = a; c.bc = b; c.din = d; c.be = e;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk(1'($urandom_range(0, 1)), AW'($urandom), BW'($urandom_range(0, 5)),
                  {$urandom, $urandom}, 8'($urandom));
    endfunction

    function automatic cmd_t front(input int p);
        return (p == 0) ? pend0[0] : pend1[0];
    endfunction

    function automatic int npend(input int p);
        return (p == 0) ? pend0.size() : pend1.size();
    endfunction

    task automatic model_update();
        cmd_t c;
        bit   g;
        if (!rst_v) begin
            m_active = 0; m_acc = 0; m_got = 0; m_last = 1;
        end else if (m_active) begin
            if (!m_acc && !busy_v) m_acc = 1;
            if (!m_we && ready_v) m_got++;
            if (m_acc && (m_we || m_got >= m_len)) m_active = 0;
        end else if (req[0] || req[1]) begin
`ifdef DDRAM_ARB_FIXPRIO_EN
            g = req[0] ? 1'b0 : 1'b1;
`else
            g = (req[0] && req[1]) ? !m_last : req[1];
`endif
            m_last = g;
            c = front(int'(g));
            m_active = 1; m_acc = 0; m_got = 0; m_port = g;
            m_we = c.we; m_addr = c.addr; m_din = c.din; m_be = c.be;
            m_len = c.we ? 1 : ((c.bc == 0) ? 1 : int'(c.bc));
        end
    endtask

    // One clock cycle: drive at negedge, compare just after, react to acks, advance model.
    task automatic cycle();
        cmd_t c;
        bit   es, ea, ev;
        @(negedge clk);
        rst_n = rst_v;
        for (int p = 0; p < 2; p++) begin
            if (npend(p) > 0) begin
                c = front(p);
                req[p] = 1'b1; we_i[p] = c.we; addr_i[p] = c.addr;
                bc_i[p] = c.bc; din_i[p] = c.din; be_i[p] = c.be;
            end else begin
                req[p] = 1'b0; we_i[p] = 1'($urandom); addr_i[p] = AW'($urandom);
                bc_i[p] = BW'($urandom); din_i[p] = {$urandom, $urandom}; be_i[p] = 8'($urandom);
            end
        end
        busy = busy_v; ready = ready_v; ddout = {$urandom, $urandom};
        #1;
        es = rst_v && m_active && !m_acc;
        chk("rd", d_rd, es && !m_we);
        chk("we", d_we, es && m_we);
        if (es) begin
            chk("addr", d_addr, m_addr);
            chk("burstcnt", d_bc, m_len);
            if (m_we) begin
                chk("din", d_din, m_din);
                chk("be", d_be, m_be);
            end
        end
        if (!rst_v) begin
            chk("rst_addr", d_addr, 0); chk("rst_bc", d_bc, 0);
            chk("rst_din", d_din, 0); chk("rst_be", d_be, 0);
        end
        for (int p = 0; p < 2; p++) begin
            ea = es && !busy_v && (m_port == p);
            ev = rst_v && m_active && !m_we && ready_v && (m_port == p);
            chk($sformatf("ack%0d", p), ack[p], ea);
            chk($sformatf("rdvalid%0d", p), rdv[p], ev);
            if (ev) chk($sformatf("dout%0d", p), dout[p], ddout);
        end
        s_rd = d_rd; s_we = d_we; s_addr = d_addr; s_bc = d_bc; s_din = d_din; s_be = d_be;
        for (int p = 0; p < 2; p++) begin
            s_ack[p] = ack[p]; s_rdv[p] = rdv[p];
            if (rdv[p] === 1'b1) rdv_cnt[p]++;
            if (ack[p] === 1'b1) begin
                ack_log.push_back(p);
                if (p == 0 && pend0.size() > 0) void'(pend0.pop_front());
                if (p == 1 && pend1.size() > 0) void'(pend1.pop_front());
                req[p] = 1'b0;
            end
        end
        model_update();
    endtask

    task automatic drain(input string name, input int lim);
        for (int i = 0; i < lim && (pend0.size() > 0 || pend1.size() > 0 || m_active); i++) cycle();
        chk(name, pend0.size() + pend1.size() + int'(m_active), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, nst, ackat, bc_seen;
        int exp_order [8];
        n_err = 0; n_chk = 0; rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        rst_v = 0; busy_v = 0; ready_v = 0; rst_n = 1'b0;
        busy = 0; ready = 0; ddout = '0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 0; we_i[p] = 0; addr_i[p] = '0; bc_i[p] = '0; din_i[p] = '0; be_i[p] = '0;
        end
        m_active = 0; m_acc = 0; m_last = 1; m_got = 0; m_len = 0; m_port = 0; m_we = 0;

        repeat (3) cycle();
        chk("reset_rd", s_rd, 0); chk("reset_we", s_we, 0);
        chk("reset_ack0", s_ack[0], 0); chk("reset_addr", s_addr, 0);
        rst_v = 1;
        cycle();

        // Single read r0 addr 0x100, burst 4
        pend0.push_back(mk(0, 'h100, 4, 0, 0));
        cycle();
        chk("t1_rd_req_cycle", s_rd, 0);
        cycle();
        chk("t1_rd_next_cycle", s_rd, 1); chk("t1_ack", s_ack[0], 1);
        chk("t1_addr", s_addr, 'h100); chk("t1_bc", s_bc, 4);
        ready_v = 1; repeat (6) cycle(); ready_v = 0;
        chk("t1_beats", rdv_cnt[0], 4);

        // r1 write with BUSY high for 5 strobe cycles
        pend1.push_back(mk(1, 'h2A, 0, 64'h1122334455667788, 8'h0F));
        busy_v = 1; cycle();
        nst = 0; ackat = 0;
        for (int i = 0; i < 6; i++) begin
            busy_v = (i < 5);
            cycle();
            if (s_we === 1'b1 && s_addr == 'h2A && s_din == 64'h1122334455667788 &&
                s_be == 8'h0F && s_bc == 1) nst++;
            if (s_ack[1] === 1'b1) ackat = i + 1;
        end
        chk("t2_stable_cycles", nst, 6); chk("t2_ack_at", ackat, 6);
        busy_v = 0; cycle();
        chk("t2_we_dropped", s_we, 0);

        // Both ports hold 4 reads each
        ack_log.delete();
        for (int i = 0; i < 4; i++) begin
            pend0.push_back(mk(0, AW'(i), 2, 0, 0));
            pend1.push_back(mk(0, AW'(16 + i), 2, 0, 0));
        end
        ready_v = 1;
        drain("t3_drain", 300);
        ready_v = 0;
`ifdef DDRAM_ARB_FIXPRIO_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        chk("t3_grants", ack_log.size(), 8);
        for (int i = 0; i < 8 && i < ack_log.size(); i++)
            chk($sformatf("t3_grant%0d", i), ack_log[i], exp_order[i]);

        // Burst 0 consumes exactly one beat; later beats in IDLE are ignored
        base = rdv_cnt[0]; bc_seen = 255;
        pend0.push_back(mk(0, 'h77, 0, 0, 0));
        ready_v = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (s_rd === 1'b1) bc_seen = int'(s_bc);
        end
        ready_v = 0;
        chk("t4_bc", bc_seen, 1); chk("t4_beats", rdv_cnt[0] - base, 1);

        // Reset after 2 of 8 beats
        base = rdv_cnt[0];
        pend0.push_back(mk(0, 'h300, 8, 0, 0));
        cycle(); cycle();
        ready_v = 1; cycle(); cycle();
        chk("t5_two_beats", rdv_cnt[0] - base, 2);
        rst_v = 0; cycle();
        chk("t5_rdv_in_reset", s_rdv[0], 0); chk("t5_rd_in_reset", s_rd, 0);
        cycle(); rst_v = 1;
        repeat (4) cycle();
        chk("t5_rest_ignored", rdv_cnt[0] - base, 2);
        ready_v = 0;
        pend1.push_back(mk(0, 'h55, 1, 0, 0));
        cycle(); cycle();
        chk("t5_next_rd", s_rd, 1); chk("t5_next_ack", s_ack[1], 1);
        ready_v = 1; cycle(); ready_v = 0;
        chk("t5_next_beat", s_rdv[1], 1);

        // Reset while a write strobe waits on BUSY: strobe drops at once, command re-issues
        busy_v = 1;
        pend1.push_back(mk(1, 'h99, 0, 64'hCAFE, 8'hFF));
        cycle(); cycle();
        chk("t6_we_up", s_we, 1);
        rst_v = 0; cycle();
        chk("t6_we_async_drop", s_we, 0);
        rst_v = 1; busy_v = 0;
        drain("t6_drain", 50);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if (pend0.size() < 2 && $urandom_range(0, 3) == 0) pend0.push_back(rnd_cmd());
            if (pend1.size() < 2 && $urandom_range(0, 3) == 0) pend1.push_back(rnd_cmd());
            busy_v = ($urandom_range(0, 3) == 0);
            ready_v = 1'($urandom_range(0, 1));
            cycle();
        end
        busy_v = 0; ready_v = 1;
        drain("rand_drain", 2000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
